// File: rtl/clk_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : clk_gen_pkg                                                   |
// | Purpose   : Shared constants and types for the clock divider bank.        |
// |             Standard half-period values assume a 50 MHz system clock,     |
// |             where output frequency = 50 MHz / (2 * half).                 |
// | Contents  : DIV_W_DEF   - default half-period register width             |
// |             HALF_*      - common half-period settings                     |
// |             ch_state_t  - per-channel divider state                       |
// |             ch_idx_w()  - width of a channel index, never below 1         |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package clk_gen_pkg;

  localparam int DIV_W_DEF  = 24;

  localparam int HALF_5MHZ  = 5;
  localparam int HALF_1MHZ  = 25;
  localparam int HALF_1KHZ  = 25000;
  localparam int HALF_100HZ = 250000;
  localparam int HALF_10HZ  = 2500000;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } ch_state_t;

  // A single-channel bank still needs a 1-bit channel select.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : clk_div_ch                                                    |
// | Purpose   : One counter-based divider channel. Produces a 50% duty       |
// |             square wave of period 2*half and a one-cycle tick on each     |
// |             rising edge. A newly written half-period is held pending and  |
// |             only becomes active at a period boundary, so no runt pulses.  |
// | Ports     : clk_50MHz  - system clock                                    |
// |             reset      - synchronous, active-high                        |
// |             en         - run enable                                      |
// |             restart    - phase-align: restart in LOW with counter 0      |
// |             wr/wr_half - store a new (legal, nonzero) pending half       |
// |             pending    - a pending half-period is waiting to be applied  |
// |             clk_out    - divided square wave (registered)                |
// |             tick       - one-cycle pulse with each clk_out rise          |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module clk_div_ch
  import clk_gen_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int DEFAULT_HALF = HALF_1MHZ
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_half,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  ch_state_t        state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] pend_half;
  logic             pend_valid;
  logic             wrap;
  logic             do_apply;

  // The active half is always >= 1 (zero writes are rejected upstream),
  // so half-1 never underflows and the counter never exceeds it.
  assign wrap = (cnt == (half - DIV_W'(1)));

  // A pending half becomes active only where no period is in flight:
  // at a restart, whenever the channel is (or is going) off, or at the
  // HIGH->LOW boundary that closes a full period.
  always_comb begin
    do_apply = 1'b0;
    if (pend_valid) begin
      do_apply = restart || !en || (state == ST_OFF) ||
                 ((state == ST_HIGH) && wrap);
    end
  end

  assign pending = pend_valid;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state      <= ST_OFF;
      cnt        <= '0;
      half       <= DIV_W'(DEFAULT_HALF);
      pend_half  <= '0;
      pend_valid <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      tick <= 1'b0;

      if (restart) begin
        state   <= en ? ST_LOW : ST_OFF;
        cnt     <= '0;
        clk_out <= 1'b0;
      end else if (!en) begin
        // Disable takes precedence over a coincident wrap: no tick.
        state   <= ST_OFF;
        cnt     <= '0;
        clk_out <= 1'b0;
      end else begin
        unique case (state)
          ST_OFF: begin
            state <= ST_LOW;
            cnt   <= '0;
          end
          ST_LOW: begin
            if (wrap) begin
              cnt     <= '0;
              clk_out <= 1'b1;
              tick    <= 1'b1;
              state   <= ST_HIGH;
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          ST_HIGH: begin
            if (wrap) begin
              cnt     <= '0;
              clk_out <= 1'b0;
              state   <= ST_LOW;
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          default: begin
            state   <= ST_OFF;
            cnt     <= '0;
            clk_out <= 1'b0;
          end
        endcase
      end

      if (do_apply) begin
        half       <= pend_half;
        pend_valid <= 1'b0;
      end

      // Writes are only accepted while nothing is pending, so they can
      // never collide with an apply in the same cycle.
      if (wr) begin
        pend_half  <= wr_half;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : clk_div_bank                                                  |
// | Purpose   : Bank of NUM_CH independent programmable clock dividers with  |
// |             a shared configuration port and a global phase restart.      |
// | Ports     : clk_50MHz    - system clock, 50 MHz                          |
// |             reset        - synchronous, active-high                      |
// |             ch_en        - per-channel run enable                        |
// |             sync_restart - one-cycle pulse, phase-aligns all channels    |
// |             cfg_valid    - configuration request                         |
// |             cfg_ready    - request can be accepted this cycle            |
// |             cfg_ch       - target channel                                |
// |             cfg_half     - new half-period in clk_50MHz cycles           |
// |             cfg_err      - pulse: last accepted request was illegal      |
// |             clk_out      - divided square waves                          |
// |             tick         - one-cycle pulse on each clk_out rising edge   |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module clk_div_bank
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = DIV_W_DEF,
  parameter int DEFAULT_HALF = HALF_1MHZ
) (
  input  logic                        clk_50MHz,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic                        sync_restart,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]            cfg_half,
  output logic                        cfg_err,
  output logic [NUM_CH-1:0]           clk_out,
  output logic [NUM_CH-1:0]           tick
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] wr;
  logic              sel_pending;
  logic              ch_legal;
  logic              half_legal;
  logic              accept;

  // One-hot channel decode. A select value with no matching channel
  // (possible when NUM_CH is not a power of two) hits nothing and reads
  // as "not pending", so such a request is still accepted and flagged.
  always_comb begin
    ch_hit      = '0;
    sel_pending = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        ch_hit[i]   = 1'b1;
        sel_pending = pending[i];
      end
    end
  end

  assign ch_legal   = |ch_hit;
  assign half_legal = |cfg_half;

  // Back-pressure while the target already holds an unapplied value, and
  // during a restart, which applies every pending value in that cycle.
  assign cfg_ready  = !sel_pending && !sync_restart;
  assign accept     = cfg_valid && cfg_ready;
  assign wr         = (accept && half_legal) ? ch_hit : '0;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= accept && !(ch_legal && half_legal);
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_ch #(
        .DIV_W        (DIV_W),
        .DEFAULT_HALF (DEFAULT_HALF)
      ) u_ch (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .en        (ch_en[g]),
        .restart   (sync_restart),
        .wr        (wr[g]),
        .wr_half   (cfg_half),
        .pending   (pending[g]),
        .clk_out   (clk_out[g]),
        .tick      (tick[g])
      );
    end
  endgenerate

endmodule
`default_nettype wire
